// File: rtl/imuldiv_mul_arbiter_pkg.sv
// Shared types for the multiplier arbiter: FSM state encoding and default operand width.
// The arbiter only steers traffic, so there is nothing arithmetic in here.
package imuldiv_mul_arb_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/imuldiv_mul_arbiter_if.sv
// Requester and multiplier val/rdy bundle; slave is the arbiter's view, master the surrounding lanes + multiplier.
// Results are twice the operand width.
interface imuldiv_mul_arbiter_if #(
  parameter int WIDTH = imuldiv_mul_arb_pkg::WIDTH_DEFAULT
);

  logic               req0_val;
  logic               req0_rdy;
  logic [WIDTH-1:0]   req0_msg_a;
  logic [WIDTH-1:0]   req0_msg_b;
  logic               req1_val;
  logic               req1_rdy;
  logic [WIDTH-1:0]   req1_msg_a;
  logic [WIDTH-1:0]   req1_msg_b;

  logic               resp0_val;
  logic               resp0_rdy;
  logic [2*WIDTH-1:0] resp0_msg_result;
  logic               resp1_val;
  logic               resp1_rdy;
  logic [2*WIDTH-1:0] resp1_msg_result;

  logic               mul_req_val;
  logic               mul_req_rdy;
  logic [WIDTH-1:0]   mul_req_msg_a;
  logic [WIDTH-1:0]   mul_req_msg_b;
  logic               mul_resp_val;
  logic               mul_resp_rdy;
  logic [2*WIDTH-1:0] mul_resp_msg_result;

  logic               owner;
  logic               busy;

  modport slave (
    input  req0_val, req0_msg_a, req0_msg_b,
    input  req1_val, req1_msg_a, req1_msg_b,
    output req0_rdy, req1_rdy,
    output resp0_val, resp0_msg_result, resp1_val, resp1_msg_result,
    input  resp0_rdy, resp1_rdy,
    output mul_req_val, mul_req_msg_a, mul_req_msg_b,
    input  mul_req_rdy,
    input  mul_resp_val, mul_resp_msg_result,
    output mul_resp_rdy,
    output owner, busy
  );

  modport master (
    output req0_val, req0_msg_a, req0_msg_b,
    output req1_val, req1_msg_a, req1_msg_b,
    input  req0_rdy, req1_rdy,
    input  resp0_val, resp0_msg_result, resp1_val, resp1_msg_result,
    output resp0_rdy, resp1_rdy,
    input  mul_req_val, mul_req_msg_a, mul_req_msg_b,
    output mul_req_rdy,
    output mul_resp_val, mul_resp_msg_result,
    input  mul_resp_rdy,
    input  owner, busy
  );

endinterface

// File: rtl/imuldiv_mul_arbiter_rr_arb2.sv
// Two-way round-robin pick: the pointed-to requester wins if valid, else the other one.
// Purely combinational; o_id is meaningless while o_gnt is low.
module imuldiv_rr_arb2 (
  input  logic i_val0,
  input  logic i_val1,
  input  logic i_ptr,
  output logic o_gnt,
  output logic o_id
);

  logic w_ptr_val;

  assign w_ptr_val = i_ptr ? i_val1 : i_val0;
  assign o_gnt     = i_val0 | i_val1;
  assign o_id      = w_ptr_val ? i_ptr : ~i_ptr;

endmodule

// File: rtl/imuldiv_mul_arbiter.sv
// Shares one iterative multiplier between two requesters; zero added latency, one op in flight.
// Backpressure: a stalled owner response holds WAIT, which in turn stalls the other requester.
module imuldiv_mul_arbiter
  import imuldiv_mul_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  imuldiv_mul_arbiter_if.slave io_arb
);

  state_t r_state;
  logic   r_ptr;
  logic   r_owner;

  logic   w_gnt;
  logic   w_id;
  logic   w_idle;
  logic   w_wait;
  logic   w_req_hs;
  logic   w_resp_hs;
  logic   w_owner_rdy;

  imuldiv_rr_arb2 u_rr_arb2 (
    .i_val0 (io_arb.req0_val),
    .i_val1 (io_arb.req1_val),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt),
    .o_id   (w_id)
  );

  // Reset gates every handshake output so nothing leaks out while the multiplier is also being reset.
  assign w_idle = !reset && (r_state == STATE_IDLE);
  assign w_wait = !reset && (r_state == STATE_WAIT);

  assign io_arb.mul_req_val   = w_idle && w_gnt;
  assign io_arb.mul_req_msg_a = w_id ? io_arb.req1_msg_a : io_arb.req0_msg_a;
  assign io_arb.mul_req_msg_b = w_id ? io_arb.req1_msg_b : io_arb.req0_msg_b;
  assign io_arb.req0_rdy      = w_idle && w_gnt && !w_id && io_arb.mul_req_rdy;
  assign io_arb.req1_rdy      = w_idle && w_gnt &&  w_id && io_arb.mul_req_rdy;

  assign w_owner_rdy              = r_owner ? io_arb.resp1_rdy : io_arb.resp0_rdy;
  assign io_arb.mul_resp_rdy      = w_wait && w_owner_rdy;
  assign io_arb.resp0_val         = w_wait && !r_owner && io_arb.mul_resp_val;
  assign io_arb.resp1_val         = w_wait &&  r_owner && io_arb.mul_resp_val;
  assign io_arb.resp0_msg_result  = io_arb.mul_resp_msg_result;
  assign io_arb.resp1_msg_result  = io_arb.mul_resp_msg_result;

  assign io_arb.owner = r_owner;
  assign io_arb.busy  = w_wait;

  assign w_req_hs  = io_arb.mul_req_val  && io_arb.mul_req_rdy;
  assign w_resp_hs = io_arb.mul_resp_val && io_arb.mul_resp_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STATE_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      case (r_state)
        STATE_IDLE: begin
          if (w_req_hs) begin
            r_owner <= w_id;
            r_ptr   <= ~w_id;
            r_state <= STATE_WAIT;
          end
        end
        STATE_WAIT: begin
          if (w_resp_hs) begin
            r_state <= STATE_IDLE;
          end
        end
        default: r_state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Directed bench for the multiplier arbiter: queue-driven requesters, a latency-LAT multiplier model,
// and a rule-level reference that predicts every handshake output each cycle.
module tb_imuldiv_mul_arbiter;

  localparam int W   = 32;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imuldiv_mul_arbiter_if #(.WIDTH(W)) ifc ();

  imuldiv_mul_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .io_arb (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- sampled handshakes (taken mid-cycle, used at the next edge)
  bit          hs0_s, hs1_s, rst_s, mreq_hs_s, mresp_hs_s;
  logic [31:0] mreq_a_s, mreq_b_s;

  always @(negedge clk) begin
    hs0_s      = ifc.req0_val && ifc.req0_rdy;
    hs1_s      = ifc.req1_val && ifc.req1_rdy;
    rst_s      = reset;
    mreq_hs_s  = ifc.mul_req_val && ifc.mul_req_rdy;
    mresp_hs_s = ifc.mul_resp_val && ifc.mul_resp_rdy;
    mreq_a_s   = ifc.mul_req_msg_a;
    mreq_b_s   = ifc.mul_req_msg_b;
  end

  // ---------------- requesters: each presents the head of its job queue
  logic [31:0] qa0[$], qb0[$], qa1[$], qb1[$];

  always @(posedge clk) begin
    #1;
    if (hs0_s && qa0.size() > 0) begin void'(qa0.pop_front()); void'(qb0.pop_front()); end
    if (hs1_s && qa1.size() > 0) begin void'(qa1.pop_front()); void'(qb1.pop_front()); end
    ifc.req0_val   = (qa0.size() > 0);
    ifc.req0_msg_a = (qa0.size() > 0) ? qa0[0] : 32'h0;
    ifc.req0_msg_b = (qb0.size() > 0) ? qb0[0] : 32'h0;
    ifc.req1_val   = (qa1.size() > 0);
    ifc.req1_msg_a = (qa1.size() > 0) ? qa1[0] : 32'h0;
    ifc.req1_msg_b = (qb1.size() > 0) ? qb1[0] : 32'h0;
  end

  // ---------------- iterative multiplier model, ready again only after its result is taken
  bit          mbusy;
  int          mcnt;
  logic [63:0] mres;
  bit          stray;

  always @(posedge clk) begin
    longint sa, sb;
    #1;
    if (rst_s) begin
      mbusy = 1'b0;
      mcnt  = 0;
    end else if (mreq_hs_s) begin
      sa    = $signed(mreq_a_s);
      sb    = $signed(mreq_b_s);
      mres  = sa * sb;
      mbusy = 1'b1;
      mcnt  = LAT;
    end else if (mresp_hs_s) begin
      mbusy = 1'b0;
    end else if (mbusy && mcnt > 0) begin
      mcnt--;
    end
    ifc.mul_req_rdy         = !mbusy;
    ifc.mul_resp_val        = (mbusy && mcnt == 0) || stray;
    ifc.mul_resp_msg_result = stray ? 64'hDEAD_BEEF_0BAD_F00D : mres;
  end

  // ---------------- reference model and per-cycle compare
  bit          m_busy, m_owner, m_fav, resp1_seen;
  int          cyc;
  logic [63:0] eq0[$], eq1[$];
  int          g_who[$], g_cyc[$], r_who[$], r_cyc[$];
  logic [63:0] r_res[$];

  always @(negedge clk) begin
    bit   [1:0]  v, rr, e_rdy, e_rv;
    logic [31:0] a[2], b[2];
    logic [63:0] exp_res;
    bit          e_mrv, e_mrr;
    int          w;
    longint      pa, pb;
    cyc++;
    v    = {ifc.req1_val, ifc.req0_val};
    rr   = {ifc.resp1_rdy, ifc.resp0_rdy};
    a[0] = ifc.req0_msg_a;  b[0] = ifc.req0_msg_b;
    a[1] = ifc.req1_msg_a;  b[1] = ifc.req1_msg_b;
    if (reset) begin
      chk("rst_req0_rdy", ifc.req0_rdy, 0);
      chk("rst_req1_rdy", ifc.req1_rdy, 0);
      chk("rst_resp0_val", ifc.resp0_val, 0);
      chk("rst_resp1_val", ifc.resp1_val, 0);
      chk("rst_mul_req_val", ifc.mul_req_val, 0);
      chk("rst_mul_resp_rdy", ifc.mul_resp_rdy, 0);
      m_busy = 0; m_owner = 0; m_fav = 0;
      eq0.delete(); eq1.delete();
    end else begin
      w = -1; e_rdy = 2'b00; e_rv = 2'b00; e_mrv = 0; e_mrr = 0;
      if (!m_busy) begin
        if (v[m_fav]) w = int'(m_fav);
        else if (v[!m_fav]) w = int'(!m_fav);
        if (w >= 0) e_rdy[w] = ifc.mul_req_rdy;
        e_mrv = (w >= 0);
      end else begin
        e_rv[m_owner] = ifc.mul_resp_val;
        e_mrr = rr[m_owner];
      end
      chk("mul_req_val", ifc.mul_req_val, e_mrv);
      chk("req0_rdy", ifc.req0_rdy, e_rdy[0]);
      chk("req1_rdy", ifc.req1_rdy, e_rdy[1]);
      chk("resp0_val", ifc.resp0_val, e_rv[0]);
      chk("resp1_val", ifc.resp1_val, e_rv[1]);
      chk("mul_resp_rdy", ifc.mul_resp_rdy, e_mrr);
      chk("owner", ifc.owner, m_owner);
      chk("busy", ifc.busy, m_busy);
      if (w >= 0) begin
        chk("mul_req_msg_a", ifc.mul_req_msg_a, a[w]);
        chk("mul_req_msg_b", ifc.mul_req_msg_b, b[w]);
      end
      if (m_busy && ifc.mul_resp_val) begin
        chk("resp0_msg_result", ifc.resp0_msg_result, ifc.mul_resp_msg_result);
        chk("resp1_msg_result", ifc.resp1_msg_result, ifc.mul_resp_msg_result);
      end
      if (!m_busy && w >= 0 && ifc.mul_req_rdy) begin
        pa = $signed(a[w]);
        pb = $signed(b[w]);
        if (w == 0) eq0.push_back(pa * pb); else eq1.push_back(pa * pb);
        g_who.push_back(w); g_cyc.push_back(cyc);
        m_owner = w[0]; m_fav = !w[0]; m_busy = 1;
      end else if (m_busy && ifc.mul_resp_val && rr[m_owner]) begin
        exp_res = 64'hX;
        if (!m_owner && eq0.size() > 0) exp_res = eq0.pop_front();
        if ( m_owner && eq1.size() > 0) exp_res = eq1.pop_front();
        chk("resp_product", ifc.mul_resp_msg_result, exp_res);
        r_who.push_back(int'(m_owner)); r_cyc.push_back(cyc);
        r_res.push_back(ifc.mul_resp_msg_result);
        m_busy = 0;
      end
    end
    if (ifc.resp1_val) resp1_seen = 1;
  end

  // ---------------- stimulus helpers
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic push(input int who, input logic [31:0] a, input logic [31:0] b);
    if (who == 0) begin qa0.push_back(a); qb0.push_back(b); end
    else          begin qa1.push_back(a); qb1.push_back(b); end
  endtask

  task automatic wait_resp(input int n);
    int i = 0;
    while (r_who.size() < n && i < 400) begin step(1); i++; end
    chk("wait_resp_timeout", 64'(r_who.size() >= n), 1);
  endtask

  task automatic wait_grant(input int n);
    int i = 0;
    while (g_who.size() < n && i < 400) begin step(1); i++; end
    chk("wait_grant_timeout", 64'(g_who.size() >= n), 1);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int gb, rb, i;
    ifc.resp0_rdy = 1'b1;
    ifc.resp1_rdy = 1'b1;
    stray = 0;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_busy", ifc.busy, 0);
    chk("reset_owner", ifc.owner, 0);
    chk("reset_mul_req_val", ifc.mul_req_val, 0);

    // single op
    push(0, 32'd3, 32'd4);
    wait_resp(1);
    chk("single_grant", g_who[0], 0);
    chk("single_who", r_who[0], 0);
    chk("single_result", r_res[0], 64'd12);
    chk("single_owner", ifc.owner, 0);
    chk("single_resp1_never", resp1_seen, 0);

    // contention right after reset
    reset = 1'b1; step(2); reset = 1'b0; step(1);
    gb = g_who.size(); rb = r_who.size();
    push(0, 32'hFFFF_FFFE, 32'd5);
    push(1, 32'd7, 32'd6);
    wait_resp(rb + 2);
    chk("cont_first", g_who[gb], 0);
    chk("cont_second", g_who[gb+1], 1);
    chk("cont_res0", r_res[rb], 64'hFFFF_FFFF_FFFF_FFF6);
    chk("cont_res1", r_res[rb+1], 64'd42);

    // fairness under continuous contention
    gb = g_who.size(); rb = r_who.size();
    push(0, 32'd1, 32'd2);  push(0, 32'd3, 32'd4);  push(0, 32'd5, 32'd6);
    push(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    push(1, 32'd100, 32'd200);
    push(1, 32'h7FFF_FFFF, 32'd2);
    wait_resp(rb + 6);
    for (int k = 0; k < 6; k++) chk("fair_order", g_who[gb+k], k % 2);
    for (int k = 0; k < 5; k++) chk("fair_idle_gap", g_cyc[gb+k+1] - r_cyc[rb+k], 1);
    chk("fair_res_last", r_res[rb+5], 64'h0000_0000_FFFF_FFFE);

    // response backpressure
    ifc.resp0_rdy = 1'b0;
    gb = g_who.size(); rb = r_who.size();
    push(0, 32'd100, 32'hFFFF_FFFD);
    wait_grant(gb + 1);
    push(1, 32'd9, 32'd9);
    i = 0;
    while (!ifc.resp0_val && i < 100) begin step(1); i++; end
    chk("bp_resp_timeout", ifc.resp0_val, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_resp0_val", ifc.resp0_val, 1);
      chk("bp_resp0_result", ifc.resp0_msg_result, 64'hFFFF_FFFF_FFFF_FED4);
      chk("bp_req1_val", ifc.req1_val, 1);
      chk("bp_req1_rdy", ifc.req1_rdy, 0);
      step(1);
    end
    ifc.resp0_rdy = 1'b1;
    wait_resp(rb + 1);
    wait_grant(gb + 2);
    chk("bp_next_who", g_who[gb+1], 1);
    chk("bp_next_cycle", g_cyc[gb+1] - r_cyc[rb], 1);
    wait_resp(rb + 2);
    chk("bp_res1", r_res[rb+1], 64'd81);

    // reset while req1 is outstanding
    resp1_seen = 0;
    gb = g_who.size(); rb = r_who.size();
    push(1, 32'd5, 32'd7);
    wait_grant(gb + 1);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(LAT + 4);
    chk("rst_mid_no_resp", r_who.size(), rb);
    chk("rst_mid_resp1_seen", resp1_seen, 0);
    chk("rst_mid_busy", ifc.busy, 0);
    push(0, 32'd2, 32'd3);
    push(1, 32'd4, 32'd5);
    wait_resp(rb + 2);
    chk("rst_mid_grant0", g_who[gb+1], 0);
    chk("rst_mid_grant1", g_who[gb+2], 1);
    chk("rst_mid_res0", r_res[rb], 64'd6);
    chk("rst_mid_res1", r_res[rb+1], 64'd20);

    // stray multiplier response while idle
    rb = r_who.size();
    stray = 1;
    step(1);
    for (int k = 0; k < 3; k++) begin
      chk("stray_mul_resp_rdy", ifc.mul_resp_rdy, 0);
      chk("stray_resp0_val", ifc.resp0_val, 0);
      chk("stray_resp1_val", ifc.resp1_val, 0);
      chk("stray_busy", ifc.busy, 0);
      step(1);
    end
    stray = 0;
    step(2);
    chk("stray_no_resp", r_who.size(), rb);
    push(0, 32'd6, 32'd7);
    wait_resp(rb + 1);
    chk("post_stray_res", r_res[rb], 64'd42);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
